// File: rtl/l1_protocol_pkg.sv
// l1_protocol_pkg
//   Shared definitions for the uncached L1 memory port: CPU access-type
//   encoding, access size lookup, natural-alignment helper and the port FSM
//   state enum. Imported by the interface user modules.
package l1_protocol_pkg;

  localparam int DATA_W = 64;
  localparam int MEM_AW = 61;

  // Access type as presented on the CPU side. Encoding 7 behaves as D.
  typedef enum logic [2:0] {
    DT_B  = 3'd0,
    DT_W  = 3'd1,
    DT_H  = 3'd2,
    DT_D  = 3'd3,
    DT_BU = 3'd4,
    DT_HU = 3'd5,
    DT_WU = 3'd6,
    DT_DX = 3'd7
  } dtype_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    CAP0 = 3'd2,
    CAP1 = 3'd3,
    WR0  = 3'd4,
    WR1  = 3'd5,
    RESP = 3'd6
  } state_e;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] size_bytes(input dtype_e dt);
    case (dt)
      DT_B, DT_BU: return 4'd1;
      DT_H, DT_HU: return 4'd2;
      DT_W, DT_WU: return 4'd4;
      default:     return 4'd8;
    endcase
  endfunction

  // Signed types get sign extension of the loaded value.
  function automatic logic sign_ext(input dtype_e dt);
    return (dt == DT_B) || (dt == DT_H) || (dt == DT_W);
  endfunction

  // Round a byte offset down to the natural alignment of the access size.
  function automatic logic [2:0] natural_offset(input logic [2:0] off,
                                                input logic [3:0] size);
    logic [3:0] m;
    m = size - 4'd1;
    return off & ~m[2:0];
  endfunction

endpackage

// File: rtl/uncached_memory_port_if.sv
// uncached_memory_port_if
//   Bundles the CPU-side request/response signals and the doubleword memory
//   signals of the uncached memory port.
//   slave  : view used by the port itself (accepts CPU requests, drives memory)
//   master : view used by the environment (issues requests, models memory)
//   cpu_to_l1__*  : valid/ready request, we, byte addr, wr_data, rd_data, dtype
//   l1_to_mem__*  : 61-bit dw addr, wr_data, rd_data (1-cycle latency), en, we
interface uncached_memory_port_if;
  logic        cpu_to_l1__valid;
  logic        cpu_to_l1__ready;
  logic        cpu_to_l1__we;
  logic [63:0] cpu_to_l1__addr;
  logic [63:0] cpu_to_l1__wr_data;
  logic [63:0] cpu_to_l1__rd_data;
  logic [2:0]  cpu_to_l1__dtype;
  logic [60:0] l1_to_mem__addr;
  logic [63:0] l1_to_mem__wr_data;
  logic [63:0] l1_to_mem__rd_data;
  logic        l1_to_mem__en;
  logic        l1_to_mem__we;

  modport slave (
    input  cpu_to_l1__valid, cpu_to_l1__we, cpu_to_l1__addr,
           cpu_to_l1__wr_data, cpu_to_l1__dtype, l1_to_mem__rd_data,
    output cpu_to_l1__ready, cpu_to_l1__rd_data, l1_to_mem__addr,
           l1_to_mem__wr_data, l1_to_mem__en, l1_to_mem__we
  );

  modport master (
    output cpu_to_l1__valid, cpu_to_l1__we, cpu_to_l1__addr,
           cpu_to_l1__wr_data, cpu_to_l1__dtype, l1_to_mem__rd_data,
    input  cpu_to_l1__ready, cpu_to_l1__rd_data, l1_to_mem__addr,
           l1_to_mem__wr_data, l1_to_mem__en, l1_to_mem__we
  );
endinterface

// File: rtl/byte_lane_aligner.sv
// byte_lane_aligner
//   Combinational byte-lane steering between a 16-byte window {dw1,dw0} and
//   the CPU's right-aligned data.
//   dw0, dw1 : low / high doubleword of the window as read from memory
//   off      : byte offset of the access inside dw0
//   dtype    : access type (size and signedness)
//   wr_data  : right-aligned store data
//   ld_data  : extracted, extended load result
//   st_dw0/1 : window with the store bytes merged in
module byte_lane_aligner
  import l1_protocol_pkg::*;
(
  input  logic [63:0] dw0,
  input  logic [63:0] dw1,
  input  logic [2:0]  off,
  input  dtype_e      dtype,
  input  logic [63:0] wr_data,
  output logic [63:0] ld_data,
  output logic [63:0] st_dw0,
  output logic [63:0] st_dw1
);

  function automatic logic [63:0] byte_mask(input logic [3:0] sz);
    case (sz)
      4'd1:    return 64'h0000_0000_0000_00FF;
      4'd2:    return 64'h0000_0000_0000_FFFF;
      4'd4:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Truncate to the access size, then sign- or zero-extend to 64 bits.
  function automatic logic [63:0] extend(input logic [63:0] v,
                                         input logic [3:0]  sz,
                                         input logic        sx);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic signed [63:0] bx;
    logic signed [63:0] hx;
    logic signed [63:0] wx;
    b  = v[7:0];
    h  = v[15:0];
    w  = v[31:0];
    bx = b;
    hx = h;
    wx = w;
    case (sz)
      4'd1:    return sx ? bx : {56'd0, v[7:0]};
      4'd2:    return sx ? hx : {48'd0, v[15:0]};
      4'd4:    return sx ? wx : {32'd0, v[31:0]};
      default: return v;
    endcase
  endfunction

  logic [3:0]   size;
  logic [5:0]   sh;
  logic [63:0]  mask;
  logic [127:0] window;
  logic [127:0] shifted;
  logic [127:0] lane_mask;
  logic [127:0] lane_data;
  logic [127:0] merged;

  always_comb begin
    size      = size_bytes(dtype);
    sh        = {off, 3'b000};
    mask      = byte_mask(size);
    window    = {dw1, dw0};
    shifted   = window >> sh;
    ld_data   = extend(shifted[63:0], size, sign_ext(dtype));
    lane_mask = {64'd0, mask} << sh;
    lane_data = {64'd0, wr_data & mask} << sh;
    merged    = (window & ~lane_mask) | lane_data;
    st_dw0    = merged[63:0];
    st_dw1    = merged[127:64];
  end

endmodule

// File: rtl/uncached_memory_port.sv
// uncached_memory_port
//   Converts byte-addressed CPU loads/stores of 1/2/4/8 bytes into accesses on
//   a 64-bit, 61-bit-addressed doubleword memory. Sub-doubleword stores are
//   read-modify-write; stores are posted. Loads return through a one-cycle
//   ready pulse with rd_data held until the next load completes.
//   clk : clock, rst : synchronous active-high reset
//   bus : uncached_memory_port_if.slave (CPU request side + memory side)
//   Build option MISALIGNED_SPLIT_EN: accesses crossing a doubleword boundary
//   are split into two doubleword accesses. When undefined, the byte offset is
//   forced to natural alignment at acceptance and nothing ever splits.
module uncached_memory_port
  import l1_protocol_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  uncached_memory_port_if.slave bus
);

  state_e      state;
  state_e      state_nxt;

  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wr_data;
  dtype_e      req_dtype;

  logic [63:0] dw0_q;
  logic [63:0] dw1_q;
  logic [63:0] rd_data_q;

  logic [63:0] aln_dw0;
  logic [63:0] aln_dw1;
  logic [63:0] ld_data;
  logic [63:0] st_dw0;
  logic [63:0] st_dw1;

  dtype_e      acc_dtype;
  logic [3:0]  acc_size;
  logic [2:0]  acc_off;
  logic        acc_direct_wr;
  logic        split;

  logic [60:0] dw_addr;
  logic [60:0] dw_addr_nx;

  logic        mem_en;
  logic        mem_we;
  logic [60:0] mem_addr;
  logic [63:0] mem_wr_data;

  assign acc_dtype = dtype_e'(bus.cpu_to_l1__dtype);
  assign acc_size  = size_bytes(acc_dtype);

`ifdef MISALIGNED_SPLIT_EN
  logic [3:0] req_size;
  logic [3:0] span;

  assign acc_off  = bus.cpu_to_l1__addr[2:0];
  assign req_size = size_bytes(req_dtype);
  assign span     = {1'b0, req_addr[2:0]} + req_size;
  assign split    = span > 4'd8;
`else
  assign acc_off  = natural_offset(bus.cpu_to_l1__addr[2:0], acc_size);
  assign split    = 1'b0;
`endif

  // A full aligned doubleword store needs no read of the old contents.
  assign acc_direct_wr = bus.cpu_to_l1__we && (acc_size == 4'd8) && (acc_off == 3'd0);

  // Second doubleword address wraps modulo 2^61 by width.
  assign dw_addr    = req_addr[63:3];
  assign dw_addr_nx = dw_addr + 61'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.cpu_to_l1__valid) state_nxt = acc_direct_wr ? WR0 : RD0;
      RD0:  state_nxt = CAP0;
      CAP0: begin
        if (split)       state_nxt = CAP1;
        else if (req_we) state_nxt = WR0;
        else             state_nxt = RESP;
      end
      CAP1: state_nxt = req_we ? WR0 : RESP;
      WR0:  state_nxt = split ? WR1 : IDLE;
      WR1:  state_nxt = IDLE;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture; the stored offset is already the effective one.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cpu_to_l1__valid) begin
      req_we      <= bus.cpu_to_l1__we;
      req_addr    <= {bus.cpu_to_l1__addr[63:3], acc_off};
      req_wr_data <= bus.cpu_to_l1__wr_data;
      req_dtype   <= acc_dtype;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CAP0) dw0_q <= bus.l1_to_mem__rd_data;
    if (state == CAP1) dw1_q <= bus.l1_to_mem__rd_data;
  end

  // In a capture state the doubleword being captured is still on the bus,
  // so the aligner takes it directly; that lets rd_data load on RESP entry.
  assign aln_dw0 = (state == CAP0) ? bus.l1_to_mem__rd_data : dw0_q;
  assign aln_dw1 = (state == CAP1) ? bus.l1_to_mem__rd_data : dw1_q;

  byte_lane_aligner u_aligner (
    .dw0     (aln_dw0),
    .dw1     (aln_dw1),
    .off     (req_addr[2:0]),
    .dtype   (req_dtype),
    .wr_data (req_wr_data),
    .ld_data (ld_data),
    .st_dw0  (st_dw0),
    .st_dw1  (st_dw1)
  );

  always_ff @(posedge clk) begin
    if (rst)                    rd_data_q <= '0;
    else if (state_nxt == RESP) rd_data_q <= ld_data;
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (!rst) begin
      case (state)
        RD0: begin
          mem_en   = 1'b1;
          mem_addr = dw_addr;
        end
        CAP0: begin
          if (split) begin
            mem_en   = 1'b1;
            mem_addr = dw_addr_nx;
          end
        end
        WR0: begin
          mem_en      = 1'b1;
          mem_we      = 1'b1;
          mem_addr    = dw_addr;
          mem_wr_data = st_dw0;
        end
        WR1: begin
          mem_en      = 1'b1;
          mem_we      = 1'b1;
          mem_addr    = dw_addr_nx;
          mem_wr_data = st_dw1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_to_l1__ready   = (state == IDLE) || (state == RESP);
  assign bus.cpu_to_l1__rd_data = rd_data_q;
  assign bus.l1_to_mem__en      = mem_en;
  assign bus.l1_to_mem__we      = mem_we;
  assign bus.l1_to_mem__addr    = mem_addr;
  assign bus.l1_to_mem__wr_data = mem_wr_data;

endmodule

// File: doc/uncached_memory_port.md
UNCACHED_MEMORY_PORT -- requirements
Module: uncached_memory_port

Interface
REQ-001 The block SHALL have no parameters; the doubleword memory is always 61-bit addressed and 64 bits wide.
REQ-002 The block SHALL have the following ports, one per line:
  clk  input  1  single clock; all state updates on its rising edge
  rst  input  1  synchronous, active-high reset
  cpu_to_l1__valid  input  1  request present
  cpu_to_l1__ready  output  1  idle and accepting, or load data valid
  cpu_to_l1__we  input  1  1 = store, 0 = load
  cpu_to_l1__addr  input  64  byte address
  cpu_to_l1__wr_data  input  64  store data, right-aligned
  cpu_to_l1__rd_data  output  64  load result, extended to 64 bits
  cpu_to_l1__dtype  input  3  access type
  l1_to_mem__addr  output  61  doubleword address (byte address bits 63:3)
  l1_to_mem__wr_data  output  64  doubleword write data
  l1_to_mem__rd_data  input  64  read data, valid the cycle after en=1, we=0
  l1_to_mem__en  output  1  memory access strobe
  l1_to_mem__we  output  1  memory write qualifier

Function
REQ-003 dtype encoding SHALL be: 0 B, 1 W, 2 H, 3 D, 4 BU, 5 HU, 6 WU; 7 SHALL be treated as D.
REQ-004 The FSM states SHALL be IDLE, RD0, CAP0, CAP1, WR0, WR1 and RESP.
REQ-005 In IDLE, ready SHALL be 1; valid&ready SHALL latch we, addr, wr_data and dtype.
REQ-006 On acceptance, an aligned D store SHALL go to WR0; every other request SHALL go to RD0.
REQ-007 RD0 SHALL drive en=1, we=0, addr=A[63:3], then go to CAP0.
REQ-008 CAP0 SHALL capture rd_data as dw0; for a split access it SHALL also issue en=1, we=0, addr=A[63:3]+1 and go to CAP1; otherwise it SHALL go to RESP (load) or WR0 (store).
REQ-009 CAP1 SHALL capture dw1 and go to RESP (load) or WR0 (store).
REQ-010 An access SHALL be split when A[2:0] + size exceeds 8, where size = 1/2/4/8 bytes.
REQ-011 Load result: {dw1,dw0} shifted right by A[2:0]*8, truncated to size, sign-extended for B/H/W, zero-extended for BU/HU/WU/D.
REQ-012 The load result SHALL be registered into rd_data on entry to RESP and held until the next load reaches RESP.
REQ-013 RESP SHALL drive ready=1 for exactly one cycle, ignore valid, then go to IDLE.
REQ-014 Store merge: the low size bytes of wr_data SHALL replace window bytes A[2:0]..A[2:0]+size-1; all other bytes SHALL keep their read values.
REQ-015 WR0 SHALL drive en=1, we=1, addr=A[63:3] with the merged dw0, then go to WR1 if split, else IDLE.
REQ-016 WR1 SHALL drive en=1, we=1, addr=A[63:3]+1 with the merged dw1, then go to IDLE.
REQ-017 Stores SHALL be posted: no RESP, ready=0 until IDLE.
REQ-018 Load latency: accept at T, RD0 at T+1, RESP at T+3 (T+4 if split). Aligned D store: WR0 at T+1, IDLE at T+2.
REQ-019 ready SHALL be 0 in RD0, CAP0, CAP1, WR0 and WR1.
REQ-020 en SHALL be 0 in IDLE and RESP; memory outputs not being driven SHALL read 0.
REQ-021 Address wrap: A[63:3]+1 SHALL wrap modulo 2^61.

Reset
REQ-022 When rst=1, the next state SHALL be IDLE and rd_data SHALL be 0, regardless of current state.
REQ-023 While rst=1, en, we, mem addr and mem wr_data SHALL be 0.
REQ-024 Reset mid-operation SHALL abandon the request; any unissued write SHALL never be issued.

Configuration
REQ-025 With MISALIGNED_SPLIT_EN defined, accesses per REQ-010 SHALL be split into two doubleword accesses.
REQ-026 Without MISALIGNED_SPLIT_EN, A[2:0] SHALL be masked to natural size alignment at acceptance, CAP1/WR1 SHALL be unreachable, and no access SHALL ever split.

Structure
REQ-027 The dtype encodings, size lookup and FSM state enum SHALL reside in shared package l1_protocol_pkg.
REQ-028 Extraction (REQ-011) and merge (REQ-014) SHALL be implemented in one combinational sub-module, byte_lane_aligner.

Verification
REQ-029 Reset, mem dw 0x2 = 0x1122334455667788, load D @0x10 -> en, addr 0x2 at T+1; ready=1 at T+3 with rd_data 0x1122334455667788.
REQ-030 Byte 3 of dw 0x2 = 0x80: load B @0x13 -> 0xFFFFFFFFFFFFFF80; load BU @0x13 -> 0x0000000000000080.
REQ-031 dw 0x4 = 0, store B wr_data 0xAB @0x21 -> one read of addr 0x4, one write of 0x000000000000AB00; ready=0 until IDLE.
REQ-032 dw1 = 0xBBAA000000000000, dw2 = 0x000000000000DDCC, load W @0x0E:
  - macro on: reads 0x1 and 0x2 -> 0xFFFFFFFFDDCCBBAA.
  - macro off: aligned to 0x0C -> 0xFFFFFFFFBBAA0000.
REQ-033 Store D @0x40 -> no read, write addr 0x8 at T+1, ready=1 at T+2.
REQ-034 rst=1 during CAP0 of store B @0x21 -> no write ever issued; IDLE with ready=1 the cycle after rst deasserts.
